alu_rf_ctrl: RTL

ALU_RF_CTRL -- requirements
Module: alu_rf_ctrl

---
 rtl/alu_rf_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_rf_ctrl.sv
// alu_rf_ctrl: fetch/decode/execute sequencer for an ALU + register file pair.
// Accepts one 16-bit instruction at a time and drives register addresses, the ALU
// opcode and the write enable. It also latches ALU flags into psr, handles the
// conditional branch (BZ) and HALT, and counts retired instructions.
// Every output is a flop.
module alu_rf_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic [15:0] flagreg,
  output logic [4:0]  ra1,
  output logic [4:0]  ra2,
  output logic [3:0]  inst,
  output logic        regwrite,
  output logic [15:0] pc,
  output logic [4:0]  psr,
  output logic [15:0] retired,
  output logic        halted
);

  localparam logic [3:0] OpCmp  = 4'b1100;
  localparam logic [3:0] OpBz   = 4'b1101;
  localparam logic [3:0] OpHalt = 4'b1111;

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q;
  logic        accept;
  logic [3:0]  op_q;
  logic [3:0]  op_in;
  logic        alu_q;
  logic [3:0]  inst_in;
  logic [15:0] disp_q;

  // Bits that carry no meaning for this controller.
  logic unused_bits;
  assign unused_bits = ^{flagreg[15:5], instr_q[11:10]};

  assign op_q   = instr_q[15:12];
  assign op_in  = instr[15:12];
  assign alu_q  = (op_q < OpCmp);
  assign disp_q = {{6{instr_q[9]}}, instr_q[9:0]};

  // ALU select for an incoming word: opcode for ALU ops, SUB-style compare for CMP, else 0.
  always_comb begin
    inst_in = 4'd0;
    if (op_in < OpCmp) begin
      inst_in = op_in;
    end else if (op_in == OpCmp) begin
      inst_in = 4'b0001;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; acceptance needs the registered ready so the post-reset cycle is idle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (instr_ready && instr_valid) begin
          accept  = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExec;
      StExec:   state_d = (op_q == OpHalt) ? StHalt : StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  // Registered outputs and architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q     <= 16'd0;
      instr_ready <= 1'b0;
      ra1         <= 5'd0;
      ra2         <= 5'd0;
      inst        <= 4'd0;
      regwrite    <= 1'b0;
      pc          <= 16'd0;
      psr         <= 5'd0;
      retired     <= 16'd0;
      halted      <= 1'b0;
    end else begin
      instr_ready <= (state_d == StFetch);
      halted      <= (state_d == StHalt);
      // Write enable is high exactly for the EXEC cycle of an ALU op.
      regwrite    <= (state_d == StExec) && alu_q;
      if (accept) begin
        instr_q <= instr;
        ra1     <= instr[9:5];
        ra2     <= instr[4:0];
        inst    <= inst_in;
        pc      <= pc + 16'd1;
      end
      if (state_q == StExec) begin
        retired <= retired + 16'd1;
        if (op_q <= OpCmp) begin
          psr <= flagreg[4:0];
        end
        // Branch is relative to the already-incremented pc.
        if ((op_q == OpBz) && psr[3]) begin
          pc <= pc + disp_q;
        end
      end
    end
  end

endmodule
